tnn_output_accumulator: RTL
===========================

TNN_OUTPUT_ACCUMULATOR -- requirements
Module: tnn_output_accumulator

Interface
REQ-001 SHALL have parameter NUM_HIDDEN, default 10, number of hidden-neuron bits per sample (legal range 2..64).
REQ-002 SHALL have parameters C0_POS, C0_NEG, C1_POS, C1_NEG, each NUM_HIDDEN bits, default all-zero, ternary output weights per class; bit i applies to hidden neuron i.
REQ-003 SHALL define SW = clog2(NUM_HIDDEN+1)+1, the signed score width.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 in_valid  input  1  in_bit/in_last are valid this cycle.
REQ-007 in_ready  output  1  block accepts a beat this cycle.
REQ-008 in_bit  input  1  one hidden-neuron output; beats arrive in index order 0,1,2,...
REQ-009 in_last  input  1  marks the final beat of a sample.
REQ-010 out_valid  output  1  result registers hold a completed sample.
REQ-011 out_ready  input  1  consumer accepts the result.
REQ-012 out_class  output  1  winning class: 1 if score1 > score0, else 0.
REQ-013 out_score0, out_score1  output  SW each  signed two's-complement class scores.
REQ-014 out_err  output  1  sample length did not equal NUM_HIDDEN.

Function
REQ-015 SHALL implement two states: ACCUM (in_ready=1, out_valid=0) and HOLD (in_ready=0, out_valid=1).
REQ-016 An input beat SHALL be accepted only when in_valid and in_ready are both 1.
REQ-017 On each accepted beat with index k=cnt, if in_bit=1, each class score SHALL change by +1 if POS[k]=1 and NEG[k]=0, by -1 if NEG[k]=1 and POS[k]=0, otherwise 0; if in_bit=0, scores SHALL be unchanged.
REQ-018 cnt SHALL increment by 1 per accepted beat; scores SHALL never overflow SW bits.
REQ-019 A sample SHALL close on the accepted beat where in_last=1 or cnt=NUM_HIDDEN-1, whichever comes first.
REQ-020 On the closing beat, the state SHALL move to HOLD, and outputs SHALL be registered including that beat's contribution; out_valid SHALL rise on the next cycle (latency 1 cycle from the last beat).
REQ-021 out_err SHALL be 1 when the closing beat did not have both in_last=1 and cnt=NUM_HIDDEN-1; otherwise 0.
REQ-022 Ties (score1 = score0) SHALL give out_class=0.
REQ-023 In HOLD, all out_* signals SHALL remain stable until out_ready=1.
REQ-024 On the HOLD cycle with out_ready=1, the state SHALL return to ACCUM, with scores and cnt cleared to 0; one bubble cycle SHALL occur, with no input accepted in that cycle.
REQ-025 in_bit and in_last SHALL be ignored when no beat is accepted.

Reset
REQ-026 rst_n=0 SHALL immediately force: state ACCUM, cnt=0, scores 0, out_valid=0, out_class=0, out_score0=0, out_score1=0, out_err=0.
REQ-027 Reset mid-sample SHALL discard the partial sample; the first accepted beat after release SHALL be index 0.
REQ-028 The block SHALL leave reset with in_ready=1 on the first clock edge after rst_n rises.

Verification
Bench uses NUM_HIDDEN=4, C1_POS=0011, C1_NEG=1100, C0_POS=1100, C0_NEG=0000.
REQ-029 Stream 1,1,0,0 (last on beat 4) -> out_score1=+2, out_score0=0, out_class=1, out_err=0, out_valid one cycle after beat 4.
REQ-030 Stream 1,1,1,1 -> out_score1=0, out_score0=+2, out_class=0; stream 0,0,0,0 -> both scores 0, out_class=0 (tie).
REQ-031 Stream 1,0 with in_last on beat 2 -> closes early, out_score1=+1, out_score0=0, out_err=1; four beats with no in_last -> closes at beat 4, out_err=1.
REQ-032 Hold out_ready=0 for 5 cycles after out_valid -> outputs unchanged, in_ready=0 throughout; out_ready=1 -> in_ready=1 after one bubble cycle, next sample starts at index 0 with zero scores.
REQ-033 Assert rst_n=0 after 2 beats of a sample -> all outputs 0 asynchronously; after release, stream 0,0,1,1 -> out_score0=+2, out_score1=-2, out_class=0.
REQ-034 Random in_valid gaps with back-to-back samples -> results match a reference-model score for every sample.

Source files
------------

// File: rtl/tnn_output_accumulator_if.sv
// -----------------------------------------------------------------------------
// tnn_output_accumulator_if
// Bundles the bit-serial hidden-neuron input stream and the per-sample result
// stream of tnn_output_accumulator.
//   in_valid/in_ready/in_bit/in_last : one hidden-neuron bit per beat
//   out_valid/out_ready              : result handshake
//   out_class/out_score0/out_score1  : winning class and signed class scores
//   out_err                          : sample length differed from NUM_HIDDEN
// master = stream producer/result consumer, slave = the accumulator.
// -----------------------------------------------------------------------------
interface tnn_output_accumulator_if #(
    parameter int NUM_HIDDEN = 10
);
    localparam int SW = $clog2(NUM_HIDDEN + 1) + 1;

    logic          in_valid;
    logic          in_ready;
    logic          in_bit;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic          out_class;
    logic [SW-1:0] out_score0;
    logic [SW-1:0] out_score1;
    logic          out_err;

    modport master (
        output in_valid, in_bit, in_last, out_ready,
        input  in_ready, out_valid, out_class, out_score0, out_score1, out_err
    );

    modport slave (
        input  in_valid, in_bit, in_last, out_ready,
        output in_ready, out_valid, out_class, out_score0, out_score1, out_err
    );
endinterface

// File: rtl/tnn_output_accumulator.sv
// -----------------------------------------------------------------------------
// tnn_output_accumulator
// Accumulates ternary-weighted class scores over a bit-serial stream of
// hidden-neuron outputs and presents one registered result per sample.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : tnn_output_accumulator_if.slave (input beats + result handshake)
// Two states: ACCUM takes beats, HOLD presents the result until out_ready.
// The HOLD cycle that sees out_ready is the single bubble before new input.
// -----------------------------------------------------------------------------

// Per-class score update for one beat: +1, -1 or 0 from the ternary weight
// selected by the beat index, applied only when the hidden bit is 1.
module tnn_class_lane #(
    parameter int                    NUM_HIDDEN = 10,
    parameter int                    SW         = 5,
    parameter int                    CW         = 4,
    parameter logic [NUM_HIDDEN-1:0] POS        = '0,
    parameter logic [NUM_HIDDEN-1:0] NEG        = '0
) (
    input  logic [CW-1:0] idx,
    input  logic          bit_i,
    input  logic [SW-1:0] acc_i,
    output logic [SW-1:0] acc_o
);
    always_comb begin
        acc_o = acc_i;
        if (bit_i) begin
            if (POS[idx] && !NEG[idx])
                acc_o = acc_i + SW'(1);
            else if (NEG[idx] && !POS[idx])
                acc_o = acc_i - SW'(1);
        end
    end
endmodule

module tnn_output_accumulator #(
    parameter int                    NUM_HIDDEN = 10,
    parameter logic [NUM_HIDDEN-1:0] C0_POS     = '0,
    parameter logic [NUM_HIDDEN-1:0] C0_NEG     = '0,
    parameter logic [NUM_HIDDEN-1:0] C1_POS     = '0,
    parameter logic [NUM_HIDDEN-1:0] C1_NEG     = '0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    tnn_output_accumulator_if.slave       bus
);
    localparam int SW       = $clog2(NUM_HIDDEN + 1) + 1;
    localparam int CW       = $clog2(NUM_HIDDEN);
    localparam int NUM_CLS  = 2;

    // Class-indexed weight tables so the lanes can be generated in a loop.
    localparam logic [NUM_CLS-1:0][NUM_HIDDEN-1:0] POS_TAB = {C1_POS, C0_POS};
    localparam logic [NUM_CLS-1:0][NUM_HIDDEN-1:0] NEG_TAB = {C1_NEG, C0_NEG};

    typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

    state_t                       state_q, state_d;
    logic [CW-1:0]                cnt_q, cnt_d;
    logic [NUM_CLS-1:0][SW-1:0]   acc_q, acc_d, acc_nxt;
    logic [NUM_CLS-1:0][SW-1:0]   score_q, score_d;
    logic                         class_q, class_d;
    logic                         err_q, err_d;

    logic accept;
    logic at_end;
    logic close;

    for (genvar g = 0; g < NUM_CLS; g++) begin : g_lane
        tnn_class_lane #(
            .NUM_HIDDEN (NUM_HIDDEN),
            .SW         (SW),
            .CW         (CW),
            .POS        (POS_TAB[g]),
            .NEG        (NEG_TAB[g])
        ) u_lane (
            .idx   (cnt_q),
            .bit_i (bus.in_bit),
            .acc_i (acc_q[g]),
            .acc_o (acc_nxt[g])
        );
    end

    assign accept = bus.in_valid && (state_q == ACCUM);
    assign at_end = (cnt_q == CW'(NUM_HIDDEN - 1));
    // Closing on the index limit caps cnt, which also bounds the scores to
    // +/-NUM_HIDDEN so SW bits can never overflow.
    assign close  = accept && (bus.in_last || at_end);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        score_d = score_q;
        class_d = class_q;
        err_d   = err_q;
        case (state_q)
            ACCUM: begin
                if (close) begin
                    // Result includes the closing beat's contribution.
                    state_d = HOLD;
                    score_d = acc_nxt;
                    class_d = $signed(acc_nxt[1]) > $signed(acc_nxt[0]);
                    err_d   = !(bus.in_last && at_end);
                end else if (accept) begin
                    acc_d = acc_nxt;
                    cnt_d = cnt_q + CW'(1);
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    state_d = ACCUM;
                    cnt_d   = '0;
                    acc_d   = '0;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ACCUM;
            cnt_q   <= '0;
            acc_q   <= '0;
            score_q <= '0;
            class_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            score_q <= score_d;
            class_q <= class_d;
            err_q   <= err_d;
        end
    end

    assign bus.in_ready   = (state_q == ACCUM);
    assign bus.out_valid  = (state_q == HOLD);
    assign bus.out_class  = class_q;
    assign bus.out_score0 = score_q[0];
    assign bus.out_score1 = score_q[1];
    assign bus.out_err    = err_q;
endmodule
